// File: rtl/chase_sequencer.sv
// rtl/chase_sequencer.sv - single-LED chase sequencer with programmable step timebase
module chase_sequencer #(
    parameter int N     = 8,
    parameter int D     = 8,
    parameter int MS    = 5000000,
    parameter int DELAY = 176470
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic [1:0]   mode,
    input  logic [D-1:0] speed,
    output logic [N-1:0] leds,
    output logic         step_tick,
    output logic         busy
);

    localparam int            PW      = $clog2(N);
    localparam logic [PW-1:0] LAST    = PW'(N - 1);
    localparam logic [31:0]   MS_W    = 32'(MS);
    localparam logic [31:0]   DELAY_W = 32'(DELAY);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [31:0]   period_q;
    logic [PW-1:0] pos;
    logic [PW-1:0] nxt_pos;
    logic          dir;
    logic          nxt_dir;
    logic [D-1:0]  m_q;

    // m_q only changes at step boundaries, so the period never moves mid-interval
    assign period_q = MS_W + 32'(m_q) * DELAY_W;

    always_comb begin
        nxt_pos = pos;
        nxt_dir = dir;
        case (mode)
            2'b01: begin
                nxt_dir = 1'b0;
                nxt_pos = (pos == '0) ? LAST : pos - PW'(1);
            end
            2'b10: begin
                if (dir) begin
                    if (pos == LAST) begin
                        nxt_dir = 1'b0;
                        nxt_pos = LAST - PW'(1);
                    end else begin
                        nxt_pos = pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        nxt_dir = 1'b1;
                        nxt_pos = PW'(1);
                    end else begin
                        nxt_pos = pos - PW'(1);
                    end
                end
            end
            default: begin
                nxt_dir = 1'b1;
                nxt_pos = (pos == LAST) ? '0 : pos + PW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pos       <= '0;
            dir       <= 1'b1;
            m_q       <= '0;
            leds      <= '0;
            step_tick <= 1'b0;
            busy      <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            if (stop) begin
                state <= IDLE;
                cnt   <= '0;
                pos   <= '0;
                dir   <= 1'b1;
                leds  <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            m_q   <= speed;
                            cnt   <= '0;
                            if (mode == 2'b01) begin
                                pos  <= LAST;
                                dir  <= 1'b0;
                                leds <= N'(1) << LAST;
                            end else begin
                                pos  <= '0;
                                dir  <= 1'b1;
                                leds <= N'(1);
                            end
                        end
                    end
                    // HOLD resumes on the same edge pause drops, continuing from the frozen cnt
                    RUN, HOLD: begin
                        if (pause) begin
                            state <= HOLD;
                        end else begin
                            state <= RUN;
                            if (cnt == period_q) begin
                                cnt       <= '0;
                                step_tick <= 1'b1;
                                m_q       <= speed;
                                pos       <= nxt_pos;
                                dir       <= nxt_dir;
                                leds      <= N'(1) << nxt_pos;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/chase_sequencer.md
Name: chase_sequencer

Overview:
- Top-level sequencer for the chasing-LED display.
- Owns the step-rate timebase, a programmable-period counter whose terminal count is MS + M*DELAY.
- Sequences a single lit LED across N outputs: left chase, right chase or bounce.
- Provides start/stop/pause control and glitch-free speed changes by sampling the speed input only at step boundaries.

Parameters:
- N, 8, number of LEDs driven (N >= 2).
- D, 8, width of speed input.
- MS, 5000000, base step period in clk cycles.
- DELAY, 176470, extra cycles per unit of speed.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins chase from IDLE.
- stop  input  1  one-cycle pulse; returns to IDLE from any state.
- pause  input  1  level; while high in RUN, timebase and LEDs freeze.
- mode  input  2  00 left (pos increasing), 01 right (pos decreasing), 10 bounce, 11 treated as 00.
- speed  input  D  step-period selector M.
- leds  output  N  one-hot LED drive; all zero when idle.
- step_tick  output  1  registered one-cycle pulse coincident with each LED advance.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, cnt=0, pos=0, dir=up, m_q=0.
  - leds=0, step_tick=0, busy=0.
- Arithmetic:
  - cnt is 32-bit unsigned.
  - period_q = MS + m_q*DELAY, computed to 32 bits and truncated.
  - Step interval is period_q+1 cycles.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - leds=0, cnt held at 0.
  - start=1 and stop=0 -> RUN. On the same edge: m_q<=speed, cnt<=0.
    - If mode=01: pos<=N-1, dir<=down.
    - Else: pos<=0, dir<=up.
  - leds shows the start position on the cycle after start.
- RUN:
  - If cnt != period_q: cnt<=cnt+1.
  - If cnt == period_q: cnt<=0, step_tick<=1, m_q<=speed, and pos advances per the current mode.
  - step_tick is 0 on all other cycles.
- Position advance:
  - left: pos<=(pos==N-1)?0:pos+1; dir<=up.
  - right: pos<=(pos==0)?N-1:pos-1; dir<=down.
  - bounce, dir up: if pos==N-1 then dir<=down and pos<=N-2, else pos+1.
  - bounce, dir down: if pos==0 then dir<=up and pos<=1, else pos-1.
  - Endpoints are lit exactly once per bounce pass.
- Mode handling:
  - mode is sampled only at step edges.
  - Switching to bounce continues in the current dir.
- HOLD:
  - Entered from RUN on any edge with pause=1 (checked before the count/step action, so no step occurs on that edge).
  - cnt, pos, dir and m_q are frozen; leds held; step_tick=0.
  - pause=0 -> RUN; counting resumes from the frozen cnt.
- Priority:
  - stop > pause > start > count.
  - stop in any state -> IDLE next edge: leds=0, cnt=0, pos=0, dir=up, step_tick=0.
  - start while RUN or HOLD is ignored.
  - start and stop together in IDLE: remain IDLE.
- Speed changes:
  - A speed change mid-step takes effect only after the next step_tick.
  - The current interval completes at the old period.
- Invariant: leds = 1<<pos whenever busy=1.

Test Plan:
(N=8, D=4, MS=4, DELAY=2 unless stated)
1. Reset and first steps: reset_n low then high, speed=1, mode=00, start pulse.
   - leds=0x01 the cycle after start.
   - step_tick every 7 cycles; leds 0x02, 0x04 … 0x80, then wraps to 0x01.
2. Right and bounce:
   - mode=01 start -> leds 0x80, then 0x40 … 0x01 -> 0x80.
   - mode=10 start -> sequence 0x01 … 0x80, 0x40 … 0x01, 0x02; no endpoint repeated.
3. Speed change mid-interval:
   - speed 1->3 at cnt=2: current interval stays 7 cycles.
   - Subsequent intervals are 11 cycles (4+3*2+1).
   - speed=0 gives 5-cycle intervals.
4. Pause:
   - pause high at cnt=3 for 20 cycles: leds and step_tick frozen, busy=1.
   - After release, the next step_tick arrives exactly 4 cycles later.
5. Priority:
   - stop with pause=1 -> IDLE, leds=0, busy=0 next cycle.
   - start+stop together in IDLE -> stays IDLE.
   - start during RUN -> no change in pos or cnt.
6. Async reset mid-run:
   - reset_n low between clock edges at pos=5 -> leds=0, busy=0 immediately, without waiting for a clk edge.
   - After release, no activity until start.
